// File: rtl/mau_pkg.sv
// mau_pkg: shared ops, states and decode helpers for the memory access unit.
// Optional misaligned trapping is enabled by defining MISALIGN_TRAP_EN.
package mau_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic is_load(input op_e op);
    return (op <= LBU);
  endfunction

  function automatic logic is_store(input op_e op);
    return (op >= SW);
  endfunction

  function automatic logic is_subword(input op_e op);
    return (op != LW) && (op != SW);
  endfunction

  // Word ops need lane 0; halfword ops need an even lane.
  function automatic logic is_misaligned(input op_e op,
                                         input logic [1:0] lane);
    logic word_op;
    logic half_op;
    word_op = (op == LW) || (op == SW);
    half_op = (op == LH) || (op == LHU) || (op == SH);
    return (word_op && (lane != 2'b00)) || (half_op && lane[0]);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// mau_lane_merge: load extract/extend and store byte/halfword merge.
// Purely combinational; lane is the low two address bits.
module mau_lane_merge
  import mau_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] wword_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  assign half   = rword_i[{lane_i[1], 4'b0000} +: 16];
  assign byte_v = rword_i[{lane_i, 3'b000} +: 8];

  always_comb begin
    ldata_o = '0;
    unique case (op_i)
      LW:      ldata_o = rword_i;
      LH:      ldata_o = {{16{half[15]}}, half};
      LHU:     ldata_o = {16'h0000, half};
      LB:      ldata_o = {{24{byte_v[7]}}, byte_v};
      LBU:     ldata_o = {24'h000000, byte_v};
      default: ldata_o = '0;
    endcase
  end

  always_comb begin
    wword_o = rword_i;
    unique case (op_i)
      SW: wword_o = wdata_i;
      SH: wword_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SB: wword_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      default: wword_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store initiator with RMW sub-word stores.
// Define MISALIGN_TRAP_EN to trap misaligned word/halfword accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);

  state_e            state_q, state_d;
  op_e               op_q;
  op_e               req_op_e;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ldata;
  logic [DATA_W-1:0] wword;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic              bad;

  assign req_op_e  = op_e'(req_op);
  assign accept    = req_valid && req_ready;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign bad = is_misaligned(req_op_e, req_addr[1:0]);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= LW;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q    <= req_op_e;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        err_q   <= bad;
`endif
      end
      if (state_q == RD) data_q <= ReadData;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            bad:                                 state_d = RESP;
            is_store(req_op_e) && !is_subword(req_op_e): state_d = WR;
            default:                             state_d = RD;
          endcase
        end
      end
      RD:      state_d = is_load(op_q) ? RESP : WR;
      WR:      state_d = RESP;
      RESP:    state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  mau_lane_merge u_merge (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .rword_i (data_q),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .wword_o (wword)
  );

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    Address    = '0;
    WriteData  = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      RD: begin
        MemRead = 1'b1;
        Address = word_addr;
      end
      WR: begin
        MemWrite  = 1'b1;
        Address   = word_addr;
        WriteData = wword;
      end
      RESP: begin
        resp_valid = 1'b1;
`ifdef MISALIGN_TRAP_EN
        resp_err   = err_q;
        if (is_load(op_q) && !err_q) resp_rdata = ldata;
`else
        if (is_load(op_q)) resp_rdata = ldata;
`endif
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors against a small word memory.
// Expectations for the misaligned SW follow MISALIGN_TRAP_EN.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat, nrd, nwr;
  logic [31:0] wword, got;
  logic        err;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  assign ReadData = mem[Address[5:2]];

  always @(posedge clk) begin
    if (poke_en)       mem[poke_idx] <= poke_val;
    else if (MemWrite) mem[Address[5:2]] <= WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Issue one request, record bus activity until the response, then
  // optionally stall resp_ready for `hold` cycles before accepting it.
  task automatic run(input op_e op, input logic [31:0] a,
                     input logic [31:0] wd, input int hold);
    logic done;
    logic [31:0] r0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wword = '0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; wword = WriteData; end
      if (resp_valid) done = 1'b1;
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    got = resp_rdata;
    err = resp_err;
    r0 = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, r0);
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("back_idle", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    poke(4'd4, 32'h075BCD15);
    poke(4'd6, 32'hFFFFFFFF);
    poke(4'd1, 32'h11223344);
    poke(4'd0, 32'h00000000);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_bus", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_addr", Address, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(LB, 32'd17, '0, 0);
    chk("lb17", got, 32'hFFFFFFCD);
    chk("lb17_lat", lat, 32'd2);
    run(LBU, 32'd17, '0, 0);
    chk("lbu17", got, 32'h000000CD);
    run(LH, 32'd18, '0, 0);
    chk("lh18", got, 32'h0000075B);
    run(LH, 32'd16, '0, 0);
    chk("lh16", got, 32'hFFFFCD15);
    run(LHU, 32'd16, '0, 0);
    chk("lhu16", got, 32'h0000CD15);

    run(SH, 32'd18, 32'h1234BEEF, 0);
    chk("sh_nrd", nrd, 32'd1);
    chk("sh_nwr", nwr, 32'd1);
    chk("sh_wdata", wword, 32'hBEEFCD15);
    chk("sh_lat", lat, 32'd3);
    chk("sh_rdata", got, 32'd0);
    run(LW, 32'd16, '0, 0);
    chk("lw16", got, 32'hBEEFCD15);

    run(SB, 32'd27, 32'h000000AB, 0);
    chk("sb_wdata", wword, 32'hABFFFFFF);
    chk("sb_mem", mem[6], 32'hABFFFFFF);
    run(LB, 32'd27, '0, 0);
    chk("lb27", got, 32'hFFFFFFAB);
    run(LBU, 32'd24, '0, 0);
    chk("lbu24", got, 32'h000000FF);

    run(SW, 32'd0, 32'hDEADBEEF, 0);
    chk("sw_nrd", nrd, 32'd0);
    chk("sw_nwr", nwr, 32'd1);
    chk("sw_lat", lat, 32'd2);
    chk("sw_mem", mem[0], 32'hDEADBEEF);

    run(LW, 32'd16, '0, 5);
    chk("lw_stall", got, 32'hBEEFCD15);

    // Reset while the SB is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_op = SB; req_addr = 32'd4; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd", {31'b0, MemRead}, 32'd1);
    @(negedge clk);
    chk("rmw_wr", {31'b0, MemWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rst_wr_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wr_wdata", WriteData, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wr_mem", mem[1], 32'h11223344);

    run(SW, 32'd5, 32'hCAFEF00D, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_lat", lat, 32'd1);
    chk("mis_nwr", nwr, 32'd0);
    chk("mis_mem", mem[1], 32'h11223344);
`else
    chk("mis_err", {31'b0, err}, 32'd0);
    chk("mis_lat", lat, 32'd2);
    chk("mis_nwr", nwr, 32'd1);
    chk("mis_mem", mem[1], 32'hCAFEF00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator placed between the CPU datapath and the word-wide, byte-addressed data memory. It accepts one load or store request at a time and drives the memory's Address/WriteData/MemRead/MemWrite/ReadData port. It performs sign- or zero-extension for sub-word loads and read-modify-write for sub-word stores. It returns one response per request through a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32, address width for CPU and memory sides.
- DATA_W, 32, data word width; fixed at 32 and not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_op  input  3  operation: LW, LH, LHU, LB, LBU, SW, SH, SB.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  misaligned-access flag; always 0 when MISALIGN_TRAP_EN is undefined.
- Address  output  ADDR_W  memory byte address; always word-aligned.
- WriteData  output  32  memory write word.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; the memory commits on the clk edge.
- ReadData  input  32  combinational memory read data; little-endian.

## Operation
- States: IDLE, RD, WR, RESP.
- Request acceptance:
  - A request is accepted when req_valid and req_ready are both high at a clk edge.
  - On acceptance, the unit latches op, addr, and wdata.
  - Word address is {addr[31:2], 2'b00}. Byte lane is addr[1:0].
- Transitions from IDLE:
  - Loads go to RD.
  - SW goes to WR.
  - SH and SB go to RD (read-modify-write).
- RD state:
  - MemRead=1 and Address=word address.
  - At the clk edge the unit captures ReadData into a data register.
  - Loads then go to RESP. SH and SB then go to WR.
- Load extraction:
  - LB/LBU select byte ReadData[8*lane +: 8].
  - LH/LHU select halfword ReadData[16*addr[1] +: 16].
  - LB and LH sign-extend. LBU and LHU zero-extend.
- WR state:
  - MemWrite=1 and Address=word address for exactly one cycle, then go to RESP.
  - SW: WriteData=wdata.
  - SH: the captured word with halfword addr[1] replaced by wdata[15:0].
  - SB: the captured word with byte lane replaced by wdata[7:0].
- RESP state:
  - resp_valid=1, held with stable resp_rdata and resp_err until resp_ready is high.
  - Go to IDLE on the edge where resp_ready is sampled high.
- Bus idle values: outside RD and WR, MemRead=0, MemWrite=0, and Address/WriteData are driven 0.
- Reset:
  - Asynchronous; forces IDLE.
  - All outputs go to 0 immediately, except req_ready=1.
  - A reset asserted during WR deasserts MemWrite at once, so no write commits on the following edge.

## Timing
- Latency, counted in cycles from the accept edge to resp_valid:
  - Load: 2 (RD, then RESP).
  - SW: 2 (WR, then RESP).
  - SH/SB: 3 (RD, WR, then RESP).
- Throughput: one request per (latency + 1) cycles when resp_ready is held high.
- req_ready is combinational from state only, with no dependence on req_valid.
- A response handshake and a new acceptance never occur in the same cycle; the unit passes through IDLE between them.
- resp_ready asserted outside RESP is ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A word access with addr[1:0]≠0, or a halfword access with addr[0]=1, skips RD and WR and goes directly from IDLE to RESP.
  - The response has resp_err=1 and resp_rdata=0.
  - Neither MemRead nor MemWrite is asserted.
- MISALIGN_TRAP_EN undefined:
  - Misaligned low address bits are ignored: word accesses use lane 0, halfword accesses use addr[1].
  - resp_err is tied to 0.

## Structure
- Shared package mau_pkg holds:
  - the op enum (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7);
  - the state enum;
  - the helpers is_load/is_store/is_subword.
- One sub-module, mau_lane_merge, is combinational:
  - load extract and extend;
  - store byte/halfword merge.
- The FSM and registers stay in mem_access_unit.

## Test plan
- Word at address 16 holds 0x075BCD15; LB addr 17 -> resp_rdata 0xFFFFFFCD; LBU addr 17 -> 0x000000CD; LH addr 18 -> 0x0000075B.
- SH wdata 0x1234BEEF at addr 18 on word 0x075BCD15 -> one RD cycle, one WR cycle with WriteData 0xBEEFCD15; a following LW addr 16 returns 0xBEEFCD15.
- SB wdata 0xAB at addr 27 on word 0xFFFFFFFF -> WriteData 0xABFFFFFF; SW 0xDEADBEEF at addr 0 -> MemRead never high, resp after 2 cycles.
- resp_ready held low for 5 cycles after an LW -> resp_valid and resp_rdata stable, req_ready stays 0; release -> IDLE next edge.
- reset pulsed while in WR for SB at addr 4 -> MemWrite drops immediately, memory word unchanged, req_ready=1.
- With MISALIGN_TRAP_EN defined, SW at addr 5 -> resp_err=1 after 1 cycle, no MemWrite; without the macro, the same request writes word 4.
